// File: rtl/lane_congestion_detector.sv
// Per-lane vehicle occupancy tracker with a qualified, hysteretic congestion flag.
// Arrivals/departures are rising edges of debounced sensor levels.
module lane_congestion_detector #(
    parameter int CNT_W    = 8,
    parameter int MAX_OCC  = 200,
    parameter int HIGH_TH  = 12,
    parameter int LOW_TH   = 6,
    parameter int QUAL_CYC = 16,
    parameter int MIN_HOLD = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arrive_in,
    input  logic             depart_in,
    input  logic             flush,
    output logic             congested,
    output logic [CNT_W-1:0] occupancy,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int QW = $clog2(QUAL_CYC + 1);
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;

    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OCC);
    localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_TH);
    localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_TH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [QW-1:0]    QUAL_C  = QW'(QUAL_CYC);
    localparam logic [QW-1:0]    QONE_C  = QW'(1);
    localparam logic [HW-1:0]    HOLD_C  = HW'(MIN_HOLD - 1);
    localparam logic [HW-1:0]    HONE_C  = HW'(1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_ARMING = 2'd1,
        ST_CONG   = 2'd2
    } state_t;

    logic             arrive_q, depart_q;
    logic             arr_e, dep_e;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    state_t           state_q;
    logic [QW-1:0]    qual_q;
    logic [HW-1:0]    hold_q;
    logic             cong_q;

    assign arr_e = arrive_in & ~arrive_q;
    assign dep_e = depart_in & ~depart_q;

    // Occupancy next-state with saturation, floor and sticky error capture.
    always_comb begin
        occ_d = occ_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (flush) begin
            occ_d = ZERO_C;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (arr_e && !dep_e) begin
            if (occ_q == MAX_C) begin
                ovf_d = 1'b1;
            end else begin
                occ_d = occ_q + ONE_C;
            end
        end else if (dep_e && !arr_e) begin
            if (occ_q == ZERO_C) begin
                unf_d = 1'b1;
            end else begin
                occ_d = occ_q - ONE_C;
            end
        end else begin
            occ_d = occ_q;
        end
    end

    // Edge-detect history, occupancy and error registers; history samples even in reset.
    always_ff @(posedge clk) begin
        arrive_q <= arrive_in;
        depart_q <= depart_in;
        if (!rst) begin
            occ_q <= ZERO_C;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Congestion FSM, evaluated on the registered occupancy so no input reaches the flag directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_CLEAR;
            qual_q  <= '0;
            hold_q  <= '0;
            cong_q  <= 1'b0;
        end else if (flush) begin
            state_q <= ST_CLEAR;
            qual_q  <= '0;
            hold_q  <= '0;
            cong_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cong_q <= 1'b0;
                    if (occ_q >= HIGH_C) begin
                        state_q <= ST_ARMING;
                        qual_q  <= QONE_C;
                    end else begin
                        qual_q  <= '0;
                    end
                end
                ST_ARMING: begin
                    if (occ_q < HIGH_C) begin
                        state_q <= ST_CLEAR;
                        qual_q  <= '0;
                        cong_q  <= 1'b0;
                    end else if (qual_q == QUAL_C) begin
                        state_q <= ST_CONG;
                        cong_q  <= 1'b1;
                        hold_q  <= HOLD_C;
                    end else begin
                        qual_q  <= qual_q + QONE_C;
                        cong_q  <= 1'b0;
                    end
                end
                ST_CONG: begin
                    if (hold_q != '0) begin
                        hold_q <= hold_q - HONE_C;
                    end else begin
                        hold_q <= hold_q;
                    end
                    // Between LOW_TH and HIGH_TH the flag holds: that gap is the hysteresis band.
                    if (hold_q == '0 && occ_q <= LOW_C) begin
                        state_q <= ST_CLEAR;
                        cong_q  <= 1'b0;
                    end else begin
                        cong_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    qual_q  <= '0;
                    hold_q  <= '0;
                    cong_q  <= 1'b0;
                end
            endcase
        end
    end

    assign congested = cong_q;
    assign occupancy = occ_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule
